bin2bcd_seq: RTL



---
 rtl/bin2bcd_seq_if.sv | 26 ++
 rtl/bin2bcd_seq.sv | 98 +++++++++
 2 files changed

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done conversion handshake between the minute counter and bin2bcd_seq.
// The requester drives start/bin; the converter answers with busy, done, bcd and its FSM state.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  // start is honoured only while the converter is idle (busy=0); a request
  // made while busy is dropped. bin is captured on the edge that accepts start.
  // done is a one-cycle pulse marking the edge at which bcd was updated.
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [1:0]            state;

  modport master (
    output start, bin,
    input  busy, done, bcd, state
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, state
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter: WIDTH add-3/shift steps,
// then one cycle to publish the result, so a conversion takes WIDTH+1 edges.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  io
);
  localparam int SRW = 4 * DIGITS + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Too few digits would silently truncate the largest input.
  if (!(pow10(DIGITS) > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_params
    $error("bin2bcd_seq: DIGITS=%0d cannot hold 2^%0d-1", DIGITS, WIDTH);
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [SRW-1:0]      sr, sr_n, adj;
  logic [CW-1:0]       cnt, cnt_n;
  logic [4*DIGITS-1:0] bcd_q, bcd_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      bcd_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      sr     <= sr_n;
      cnt    <= cnt_n;
      bcd_q  <= bcd_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    bcd_n   = bcd_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    adj     = sr;
    // Per-nibble +3 with no carry into the next digit.
    for (int k = 0; k < DIGITS; k++) begin
      if (sr[WIDTH + 4*k +: 4] >= 4'd5)
        adj[WIDTH + 4*k +: 4] = sr[WIDTH + 4*k +: 4] + 4'd3;
    end
    case (state)
      IDLE: begin
        if (io.start) begin
          sr_n    = {{(4*DIGITS){1'b0}}, io.bin};
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        sr_n  = adj << 1;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) state_n = FINISH;
      end
      FINISH: begin
        bcd_n   = sr[SRW-1 -: 4*DIGITS];
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign io.busy  = busy_q;
  assign io.done  = done_q;
  assign io.bcd   = bcd_q;
  assign io.state = state;
endmodule
